// File: rtl/mmio_uart_tx_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: IO address
// decode constant and the transmit FSM state encoding.
package mmio_uart_tx_pkg;

  // Store address that the memory stage decodes into write_strobe.
  localparam logic [31:0] UART_IO_ADDRESS = 32'h2000;

  // Start bit + 8 data bits + stop bit.
  localparam int UART_FRAME_BITS = 10;

  typedef enum logic [1:0] {
    UART_STATE_IDLE  = 2'd0,
    UART_STATE_START = 2'd1,
    UART_STATE_DATA  = 2'd2,
    UART_STATE_STOP  = 2'd3
  } uart_state_t;

endpackage

// File: rtl/mmio_uart_tx_if.sv
// Store port from the memory stage into the UART transmitter.
// Handshake: a byte is offered for one cycle with write_strobe=1 and
// write_data valid. When store_stall=1 in that same cycle the offer is not
// taken and the master must hold strobe and data until a cycle with
// store_stall=0, in which the byte is accepted on the rising edge.
interface mmio_uart_tx_if;
  logic       write_strobe;
  logic [7:0] write_data;
  logic       store_stall;

  modport master (output write_strobe, output write_data, input store_stall);
  modport slave  (input write_strobe, input write_data, output store_stall);
endinterface

// File: rtl/mmio_uart_tx_byte_fifo.sv
// Byte FIFO with 2**DEPTH_LOG2 entries. Pointers carry one extra wrap bit
// so full and empty are distinguished without a separate count. The head
// byte is presented combinationally on pop_data.
module mmio_uart_tx_byte_fifo #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       pop,
  output logic [7:0] pop_data,
  output logic       full,
  output logic       empty
);

  logic [DEPTH_LOG2:0]   wr_ptr;
  logic [DEPTH_LOG2:0]   rd_ptr;
  logic [7:0]            mem [2**DEPTH_LOG2];

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) &&
                    (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);
  assign pop_data = mem[rd_ptr[DEPTH_LOG2-1:0]];

  // Pointer advance; push and pop may happen on the same edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write; the slot being popped on a full push+pop is read before it is overwritten.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[DEPTH_LOG2-1:0]] <= push_data;
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped UART transmitter: buffers single-cycle stores in a byte
// FIFO and serialises them as 8N1 frames on uart_tx.
// Optional macro UART_TX_BACKPRESSURE_EN: when defined, a store into a full
// FIFO raises store_stall instead of being dropped; when undefined, such
// stores are discarded and counted in dropped_count (saturating at 255).
module mmio_uart_tx
  import mmio_uart_tx_pkg::*;
#(
  parameter int CLOCK_HZ        = 12000000,
  parameter int BAUD            = 115200,
  parameter int DIVIDER         = CLOCK_HZ / BAUD,
  parameter int FIFO_DEPTH_LOG2 = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  mmio_uart_tx_if.slave        bus,
  output logic                 uart_tx,
  output logic                 fifo_empty,
  output logic                 fifo_full,
  output logic                 busy,
  output logic [7:0]           dropped_count,
  output uart_state_t          fsm_state
);

  localparam int CNT_W = (DIVIDER > 1) ? $clog2(DIVIDER) : 1;

  if (DIVIDER < 2) begin : g_bad_divider
    $error("mmio_uart_tx: DIVIDER (CLOCK_HZ/BAUD) must be at least 2");
  end

  uart_state_t      state;
  logic [CNT_W-1:0] baud_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift;
  logic [7:0]       pop_data;
  logic             baud_end;
  logic             pop;
  logic             push;
  logic             reject;

  assign baud_end  = (baud_cnt == CNT_W'(DIVIDER - 1));
  // A new frame starts from IDLE or straight out of the last STOP cycle.
  assign pop       = !fifo_empty &&
                     ((state == UART_STATE_IDLE) ||
                      ((state == UART_STATE_STOP) && baud_end));
  assign push      = bus.write_strobe && (!fifo_full || pop);
  assign reject    = bus.write_strobe && fifo_full && !pop;
  assign busy      = (state != UART_STATE_IDLE) || !fifo_empty;
  assign fsm_state = state;

  mmio_uart_tx_byte_fifo #(
    .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (bus.write_data),
    .pop       (pop),
    .pop_data  (pop_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Frame sequencer: baud counter, bit index, shift register and registered line.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= UART_STATE_IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      uart_tx  <= 1'b1;
    end else begin
      case (state)
        UART_STATE_IDLE: begin
          if (pop) begin
            state    <= UART_STATE_START;
            baud_cnt <= '0;
            shift    <= pop_data;
            uart_tx  <= 1'b0;
          end
        end
        UART_STATE_START: begin
          if (baud_end) begin
            state    <= UART_STATE_DATA;
            baud_cnt <= '0;
            bit_idx  <= '0;
            uart_tx  <= shift[0];
          end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
          end
        end
        UART_STATE_DATA: begin
          if (baud_end) begin
            baud_cnt <= '0;
            shift    <= {1'b0, shift[7:1]};
            bit_idx  <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
              state   <= UART_STATE_STOP;
              uart_tx <= 1'b1;
            end else begin
              uart_tx <= shift[1];
            end
          end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
          end
        end
        UART_STATE_STOP: begin
          if (baud_end) begin
            baud_cnt <= '0;
            if (pop) begin
              state   <= UART_STATE_START;
              shift   <= pop_data;
              uart_tx <= 1'b0;
            end else begin
              state   <= UART_STATE_IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
          end
        end
        default: begin
          state   <= UART_STATE_IDLE;
          uart_tx <= 1'b1;
        end
      endcase
    end
  end

`ifdef UART_TX_BACKPRESSURE_EN
  // Stalled stores are re-presented by the memory stage, so nothing is lost.
  assign bus.store_stall = reject;
  assign dropped_count   = 8'd0;
`else
  assign bus.store_stall = 1'b0;

  // Saturating count of stores discarded because the FIFO was full.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dropped_count <= 8'd0;
    end else if (reject && (dropped_count != 8'hFF)) begin
      dropped_count <= dropped_count + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Bench for mmio_uart_tx with DIVIDER=10 and a 4-entry FIFO. Stimulus pushes
// hand-computed expected bytes into exp_q; an independent line monitor
// decodes every frame on uart_tx and compares it with the queue head.
module tb_mmio_uart_tx;
  import mmio_uart_tx_pkg::*;

  localparam int DIV = 10;

  logic        clk;
  logic        reset;
  logic        uart_tx;
  logic        fifo_empty;
  logic        fifo_full;
  logic        busy;
  logic [7:0]  dropped_count;
  uart_state_t fsm_state;

  mmio_uart_tx_if bus();

  mmio_uart_tx #(
    .CLOCK_HZ        (1000),
    .BAUD            (100),
    .FIFO_DEPTH_LOG2 (2)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .bus           (bus),
    .uart_tx       (uart_tx),
    .fifo_empty    (fifo_empty),
    .fifo_full     (fifo_full),
    .busy          (busy),
    .dropped_count (dropped_count),
    .fsm_state     (fsm_state)
  );

  int         checks   = 0;
  int         failures = 0;
  int         cyc      = 0;
  logic [7:0] exp_q[$];
  int         start_cyc_q[$];

  // Clock and cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Global time limit
  initial begin
    #500000;
    $display("FAIL global_timeout: sim time exceeded, required finish earlier");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Driver: offer a byte at the negedge, hold while stalled (bounded).
  task automatic drive_write(input logic [7:0] d, output int stall_cycles);
    stall_cycles = 0;
    @(negedge clk);
    bus.write_strobe = 1'b1;
    bus.write_data   = d;
    #1;
    while (bus.store_stall && stall_cycles < 400) begin
      @(negedge clk);
      #1;
      stall_cycles++;
    end
  endtask

  task automatic drive_idle();
    @(negedge clk);
    bus.write_strobe = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n;
    n = 0;
    while ((busy || exp_q.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (busy || exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s_drain: busy=%0b pending=%0d expected idle and 0", name, busy, exp_q.size());
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic adv(input int n, inout bit ab);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (reset) ab = 1'b1;
    end
  endtask

  // Monitor: decode 8N1 frames mid-bit and score them against exp_q.
  initial begin : monitor
    logic       prev;
    logic [7:0] rx;
    logic [7:0] e;
    bit         ab;
    prev = 1'b1;
    rx   = 8'h00;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev = 1'b1;
      end else begin
        if (prev && !uart_tx) begin
          start_cyc_q.push_back(cyc);
          ab = 1'b0;
          adv(DIV / 2, ab);
          if (!ab) check("start_bit", {31'd0, uart_tx}, 32'd0);
          for (int b = 0; b < 8 && !ab; b++) begin
            adv(DIV, ab);
            rx[b] = uart_tx;
          end
          if (!ab) adv(DIV, ab);
          if (!ab) begin
            check("stop_bit", {31'd0, uart_tx}, 32'd1);
            if (exp_q.size() == 0) begin
              checks++;
              failures++;
              $display("FAIL unexpected_frame: got %02h expected no frame", rx);
            end else begin
              e = exp_q.pop_front();
              check("frame_byte", {24'd0, rx}, {24'd0, e});
            end
          end
        end
        prev = uart_tx;
      end
    end
  end

  // Directed test sequence
  initial begin : stimulus
    int st;
`ifdef UART_TX_BACKPRESSURE_EN
    localparam bit BP = 1'b1;
`else
    localparam bit BP = 1'b0;
`endif
    bus.write_strobe = 1'b0;
    bus.write_data   = 8'h00;
    reset            = 1'b1;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_uart_tx", {31'd0, uart_tx}, 32'd1);
    check("rst_fifo_empty", {31'd0, fifo_empty}, 32'd1);
    check("rst_fifo_full", {31'd0, fifo_full}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_dropped", {24'd0, dropped_count}, 32'd0);
    check("rst_state", {30'd0, fsm_state}, {30'd0, UART_STATE_IDLE});
    check("rst_stall", {31'd0, bus.store_stall}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Single byte A5: latency and frame length
    start_cyc_q.delete();
    exp_q.push_back(8'hA5);
    drive_write(8'hA5, st);
    @(posedge clk); #1;
    bus.write_strobe = 1'b0;
    check("t1_push_line_idle", {31'd0, uart_tx}, 32'd1);
    check("t1_push_busy", {31'd0, busy}, 32'd1);
    check("t1_push_not_empty", {31'd0, fifo_empty}, 32'd0);
    @(posedge clk); #1;
    check("t1_pop_line_low", {31'd0, uart_tx}, 32'd0);
    check("t1_pop_state", {30'd0, fsm_state}, {30'd0, UART_STATE_START});
    check("t1_pop_empty", {31'd0, fifo_empty}, 32'd1);
    repeat (99) @(posedge clk);
    #1;
    check("t1_last_stop_state", {30'd0, fsm_state}, {30'd0, UART_STATE_STOP});
    check("t1_last_stop_busy", {31'd0, busy}, 32'd1);
    @(posedge clk); #1;
    check("t1_end_state", {30'd0, fsm_state}, {30'd0, UART_STATE_IDLE});
    check("t1_end_busy", {31'd0, busy}, 32'd0);
    check("t1_end_empty", {31'd0, fifo_empty}, 32'd1);
    check("t1_end_line", {31'd0, uart_tx}, 32'd1);
    check("t1_frames_scored", exp_q.size(), 32'd0);
    repeat (5) @(negedge clk);

    // Three back-to-back bytes, contiguous frames
    start_cyc_q.delete();
    exp_q.push_back(8'h01);
    exp_q.push_back(8'h02);
    exp_q.push_back(8'h03);
    drive_write(8'h01, st);
    drive_write(8'h02, st);
    drive_write(8'h03, st);
    drive_idle();
    wait_drain("t2", 500);
    check("t2_frame_count", start_cyc_q.size(), 32'd3);
    if (start_cyc_q.size() == 3) begin
      check("t2_gap_1_2", start_cyc_q[1] - start_cyc_q[0], 32'd100);
      check("t2_gap_2_3", start_cyc_q[2] - start_cyc_q[1], 32'd100);
    end

    // Six consecutive writes: overflow drop or stall
    start_cyc_q.delete();
    for (int i = 1; i <= 5; i++) exp_q.push_back(8'(i));
    if (BP) exp_q.push_back(8'h06);
    for (int i = 1; i <= 5; i++) drive_write(8'(i), st);
    drive_write(8'h06, st);
    check("t3_stall_cycles", st, BP ? 32'd96 : 32'd0);
    drive_idle();
    check("t3_fifo_full", {31'd0, fifo_full}, 32'd1);
    check("t3_dropped", {24'd0, dropped_count}, BP ? 32'd0 : 32'd1);
    wait_drain("t3", 900);
    check("t3_frame_count", start_cyc_q.size(), BP ? 32'd6 : 32'd5);
    check("t3_dropped_after", {24'd0, dropped_count}, BP ? 32'd0 : 32'd1);

    // Asynchronous reset during DATA bit 3 of FF with a second byte queued
    drive_write(8'hFF, st);
    drive_write(8'hFF, st);
    drive_idle();
    repeat (44) @(posedge clk);
    #2;
    check("t4_pre_state", {30'd0, fsm_state}, {30'd0, UART_STATE_DATA});
    check("t4_pre_not_empty", {31'd0, fifo_empty}, 32'd0);
    reset = 1'b1;
    #1;
    check("t4_rst_line", {31'd0, uart_tx}, 32'd1);
    check("t4_rst_empty", {31'd0, fifo_empty}, 32'd1);
    check("t4_rst_state", {30'd0, fsm_state}, {30'd0, UART_STATE_IDLE});
    check("t4_rst_busy", {31'd0, busy}, 32'd0);
    check("t4_rst_dropped", {24'd0, dropped_count}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    start_cyc_q.delete();
    repeat (300) @(negedge clk);
    check("t4_no_residual_frame", start_cyc_q.size(), 32'd0);
    check("t4_line_idle", {31'd0, uart_tx}, 32'd1);

`ifndef UART_TX_BACKPRESSURE_EN
    // 300 writes into a saturating drop counter
    start_cyc_q.delete();
    for (int i = 1; i <= 5; i++) exp_q.push_back(8'(i));
    exp_q.push_back(8'd102);
    exp_q.push_back(8'd202);
    for (int i = 1; i <= 300; i++) drive_write(8'(i), st);
    drive_idle();
    check("t5_dropped_sat", {24'd0, dropped_count}, 32'd255);
    check("t5_fifo_full", {31'd0, fifo_full}, 32'd1);
    wait_drain("t5", 1200);
    check("t5_frame_count", start_cyc_q.size(), 32'd7);
    check("t5_dropped_hold", {24'd0, dropped_count}, 32'd255);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mmio_uart_tx.md
Name: mmio_uart_tx

Overview:
Downstream consumer of the memory stage's byte-wide memory-mapped IO port. Each store to the IO address produces a one-cycle write strobe plus data byte. The byte is buffered in a small FIFO and serialised as 8N1 UART frames on a single output pin. The block decouples single-cycle processor stores from slow serial transmission.

Parameters:
- CLOCK_HZ, 12000000: core clock frequency.
- BAUD, 115200: line rate.
- DIVIDER, CLOCK_HZ/BAUD: cycles per bit. Must be >= 2. Elaborate-time error if smaller.
- FIFO_DEPTH_LOG2, 4: FIFO holds 2**FIFO_DEPTH_LOG2 bytes.

Ports:
- clk  in  1  core clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- write_strobe  in  1  one-cycle pulse from the memory stage on a store to 0x2000.
- write_data  in  8  byte to transmit, qualified by write_strobe.
- uart_tx  out  1  serial line, idle high.
- fifo_empty  out  1  FIFO holds no bytes.
- fifo_full  out  1  FIFO holds 2**FIFO_DEPTH_LOG2 bytes.
- busy  out  1  FSM not in IDLE, or FIFO not empty.
- dropped_count  out  8  saturating count of rejected writes.
- store_stall  out  1  backpressure request to the memory stage; see Optional Feature.

Behaviour:
- Reset values (asynchronous): uart_tx=1, FIFO pointers=0, fifo_empty=1, fifo_full=0, busy=0, dropped_count=0, FSM=IDLE, baud counter=0, bit index=0. Reset mid-frame aborts the frame immediately and the line returns high.
- FIFO: registered read/write pointers, each FIFO_DEPTH_LOG2+1 bits wide. Full when the MSBs differ and the low bits are equal. Empty when the pointers are equal. Storage is a register array.
- Push: on a clock edge with write_strobe=1, the byte is accepted if the FIFO is not full, or if a pop occurs on the same edge. Otherwise the byte is rejected and dropped_count increments, saturating at 255.
- Pop: occurs only when the FSM leaves IDLE or STOP to start a new frame. The popped byte is latched into the shift register.
- FSM states and transitions:
  - IDLE: uart_tx=1. If the FIFO is non-empty, pop, go to START, and clear the baud counter.
  - START: uart_tx=0 for DIVIDER cycles, then go to DATA with bit index=0.
  - DATA: uart_tx=shift[0] for DIVIDER cycles per bit, LSB first. After each bit, shift right and increment the bit index. After bit 7, go to STOP.
  - STOP: uart_tx=1 for DIVIDER cycles. At the end, if the FIFO is non-empty, pop and go directly to START (no idle gap). Otherwise go to IDLE.
- uart_tx is a registered output, so it is glitch-free.
- Latency: a byte pushed into an empty FIFO at edge N is popped at edge N+1, and uart_tx falls after edge N+1. One frame lasts exactly 10*DIVIDER cycles.
- Baud counter runs from 0 to DIVIDER-1 and wraps. It is active only outside IDLE.
- Simultaneous push and pop when full: both occur and the count is unchanged.
- Simultaneous push and pop when empty is impossible, because a pop requires a non-empty FIFO.

Optional Feature:
- Macro UART_TX_BACKPRESSURE_EN.
- Defined: store_stall = write_strobe && fifo_full && !pop_this_cycle (combinational). The memory stage must hold the store and re-present it until it is accepted. In this mode writes are never dropped and dropped_count stays 0.
- Undefined: store_stall is tied to 0, and overflowing writes are dropped and counted as described above.

Decomposition:
- The shared define header gains:
  - UART_IO_ADDRESS (32'h2000)
  - FSM state encodings UART_STATE_IDLE, UART_STATE_START, UART_STATE_DATA, UART_STATE_STOP (2 bits)
- Sub-module byte_fifo: parameterised by depth log2, with push/pop/full/empty ports.
- The FSM and baud counter stay in mmio_uart_tx.

Test Plan (CLOCK_HZ=1000, BAUD=100, so DIVIDER=10; FIFO_DEPTH_LOG2=2):
- Reset, then one write of 8'hA5 -> uart_tx low for cycles 1-10 after the pop. Then bits 1,0,1,0,0,1,0,1, each 10 cycles. Then high for 10 cycles. Then IDLE, with busy=0 and fifo_empty=1.
- Three back-to-back writes 8'h01, 8'h02, 8'h03 -> three contiguous frames totalling 300 cycles with no idle gap. Decoded bytes match in order.
- Six writes in consecutive cycles (macro undefined) -> first frame pops byte 1, bytes 2-5 fill the FIFO and fifo_full=1, byte 6 is dropped and dropped_count=1. Exactly five frames are emitted.
- Same stimulus with UART_TX_BACKPRESSURE_EN defined -> store_stall=1 on the sixth write until the next pop. All six bytes are transmitted and dropped_count=0.
- Assert reset during DATA bit 3 of 8'hFF -> uart_tx=1 immediately (asynchronous), fifo_empty=1, no residual frame after reset is released.
- 300 writes into a full FIFO with the macro undefined -> dropped_count saturates at 255.
